// File: rtl/snoop_bus_controller.sv
// rtl/snoop_bus_controller.sv - snoop bus arbiter and memory controller for N_CPU cache nodes
//
// Serialises read-miss / write-miss / invalidate requests with round-robin
// arbitration, writes back evicted victims, broadcasts each request on the
// snoop bus, takes flush data from a Modified owner and returns fill data.
// Main memory (2**ADDR_W words of DATA_W) lives in this block.
//
// Ports:
//   clock, reset_n                     clock, asynchronous active-low reset
//   req_read_miss/write_miss/invalidate per-CPU level requests, held until resp_valid
//   req_address                        per-CPU request address, CPU i at [i*ADDR_W +: ADDR_W]
//   req_wb_valid/wb_address/wb_data    per-CPU Modified victim to write back
//   grant                              one-hot current bus owner
//   snoop_valid/op/address/src         one-cycle snoop broadcast
//   snoop_hit_modified/snoop_data      snooper flush response, cycle after snoop_valid
//   resp_valid/resp_data               one-cycle completion to the requester
//   busy                               controller not idle
//
// Optional: define BUS_STATS_EN to add saturating 8-bit counters
//   stat_read_miss, stat_write_miss, stat_invalidate, stat_flush.
module snoop_bus_controller #(
   parameter int N_CPU   = 2,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 4,
   parameter int MEM_LAT = 2
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [N_CPU-1:0]          req_read_miss,
   input  logic [N_CPU-1:0]          req_write_miss,
   input  logic [N_CPU-1:0]          req_invalidate,
   input  logic [N_CPU*ADDR_W-1:0]   req_address,
   input  logic [N_CPU-1:0]          req_wb_valid,
   input  logic [N_CPU*ADDR_W-1:0]   req_wb_address,
   input  logic [N_CPU*DATA_W-1:0]   req_wb_data,
   output logic [N_CPU-1:0]          grant,
   output logic                      snoop_valid,
   output logic [1:0]                snoop_op,
   output logic [ADDR_W-1:0]         snoop_address,
   output logic [1:0]                snoop_src,
   input  logic [N_CPU-1:0]          snoop_hit_modified,
   input  logic [N_CPU*DATA_W-1:0]   snoop_data,
   output logic [N_CPU-1:0]          resp_valid,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      busy
`ifdef BUS_STATS_EN
   ,
   output logic [7:0]                stat_read_miss,
   output logic [7:0]                stat_write_miss,
   output logic [7:0]                stat_invalidate,
   output logic [7:0]                stat_flush
`endif
);

   localparam int         DEPTH  = 2**ADDR_W;
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b10;
   localparam logic [1:0] OP_INV  = 2'b11;

   typedef enum logic [2:0] {S_IDLE, S_WB, S_SNOOP, S_COLLECT, S_MEM, S_RESP} state_t;

   state_t              state_q;
   logic [1:0]          rr_q, src_q, op_q;
   logic [ADDR_W-1:0]   addr_q, wb_addr_q;
   logic [DATA_W-1:0]   wb_data_q;
   logic                wb_valid_q;
   logic [7:0]          cnt_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic [N_CPU-1:0]    grant_q, resp_valid_q;
   logic                snoop_valid_q, busy_q;
   logic [1:0]          snoop_op_q, snoop_src_q;
   logic [ADDR_W-1:0]   snoop_addr_q;
   logic [DATA_W-1:0]   resp_data_q;

   logic [N_CPU-1:0]    req_vec;
   logic                pick_found_d, lo_found_d;
   logic [1:0]          pick_idx_d, lo_idx_d, pick_op_d;
   logic [ADDR_W-1:0]   pick_addr_d, pick_wb_addr_d;
   logic [DATA_W-1:0]   pick_wb_data_d;
   logic                pick_wb_valid_d;
   logic                hit_found_d;
   logic [DATA_W-1:0]   hit_data_d;

   assign req_vec = req_read_miss | req_write_miss | req_invalidate;

   // Round robin: first requester at or after rr_q, else wrap to the lowest requester.
   always_comb begin
      pick_found_d = 1'b0;
      pick_idx_d   = '0;
      lo_found_d   = 1'b0;
      lo_idx_d     = '0;
      for (int i = 0; i < N_CPU; i++) begin
         if (req_vec[i]) begin
            if (!lo_found_d) begin
               lo_found_d = 1'b1;
               lo_idx_d   = 2'(i);
            end
            if (!pick_found_d && i >= int'(rr_q)) begin
               pick_found_d = 1'b1;
               pick_idx_d   = 2'(i);
            end
         end
      end
      if (!pick_found_d) begin
         pick_found_d = lo_found_d;
         pick_idx_d   = lo_idx_d;
      end
   end

   // Fields of the winning CPU; write miss outranks invalidate outranks read miss.
   always_comb begin
      pick_op_d       = OP_NONE;
      pick_addr_d     = '0;
      pick_wb_addr_d  = '0;
      pick_wb_data_d  = '0;
      pick_wb_valid_d = 1'b0;
      for (int i = 0; i < N_CPU; i++) begin
         if (2'(i) == pick_idx_d) begin
            pick_op_d       = req_write_miss[i] ? OP_WR :
                              req_invalidate[i] ? OP_INV : OP_RD;
            pick_addr_d     = req_address[i*ADDR_W +: ADDR_W];
            pick_wb_addr_d  = req_wb_address[i*ADDR_W +: ADDR_W];
            pick_wb_data_d  = req_wb_data[i*DATA_W +: DATA_W];
            pick_wb_valid_d = req_wb_valid[i];
         end
      end
   end

   // Lowest-index Modified owner other than the requester supplies the flush.
   always_comb begin
      hit_found_d = 1'b0;
      hit_data_d  = '0;
      for (int i = 0; i < N_CPU; i++) begin
         if (!hit_found_d && snoop_hit_modified[i] && 2'(i) != src_q) begin
            hit_found_d = 1'b1;
            hit_data_d  = snoop_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         rr_q          <= '0;
         src_q         <= '0;
         op_q          <= OP_NONE;
         addr_q        <= '0;
         wb_addr_q     <= '0;
         wb_data_q     <= '0;
         wb_valid_q    <= 1'b0;
         cnt_q         <= '0;
         grant_q       <= '0;
         snoop_valid_q <= 1'b0;
         snoop_op_q    <= OP_NONE;
         snoop_addr_q  <= '0;
         snoop_src_q   <= '0;
         resp_valid_q  <= '0;
         resp_data_q   <= '0;
         busy_q        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef BUS_STATS_EN
         stat_read_miss  <= '0;
         stat_write_miss <= '0;
         stat_invalidate <= '0;
         stat_flush      <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_found_d) begin
                  src_q      <= pick_idx_d;
                  op_q       <= pick_op_d;
                  addr_q     <= pick_addr_d;
                  wb_addr_q  <= pick_wb_addr_d;
                  wb_data_q  <= pick_wb_data_d;
                  wb_valid_q <= pick_wb_valid_d;
                  grant_q    <= N_CPU'(1) << pick_idx_d;
                  busy_q     <= 1'b1;
                  state_q    <= S_WB;
               end
            end
            S_WB: begin
               // Victim lands before the snoop so a same-address fill sees it.
               if (wb_valid_q) mem_q[wb_addr_q] <= wb_data_q;
               snoop_valid_q <= 1'b1;
               snoop_op_q    <= op_q;
               snoop_addr_q  <= addr_q;
               snoop_src_q   <= src_q;
               state_q       <= S_SNOOP;
            end
            S_SNOOP: begin
               snoop_valid_q <= 1'b0;
               snoop_op_q    <= OP_NONE;
               snoop_addr_q  <= '0;
               snoop_src_q   <= '0;
               state_q       <= S_COLLECT;
            end
            S_COLLECT: begin
               if (hit_found_d) begin
                  mem_q[addr_q] <= hit_data_d;
`ifdef BUS_STATS_EN
                  if (stat_flush != 8'hFF) stat_flush <= stat_flush + 8'd1;
`endif
               end
               if (op_q == OP_INV || hit_found_d) begin
                  resp_valid_q <= N_CPU'(1) << src_q;
                  resp_data_q  <= (op_q == OP_INV) ? '0 : hit_data_d;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_MEM;
               end
            end
            S_MEM: begin
               if (cnt_q == 8'(MEM_LAT-1)) begin
                  resp_valid_q <= N_CPU'(1) << src_q;
                  resp_data_q  <= mem_q[addr_q];
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RESP: begin
               resp_valid_q <= '0;
               resp_data_q  <= '0;
               grant_q      <= '0;
               busy_q       <= 1'b0;
               rr_q         <= (int'(src_q) == N_CPU-1) ? 2'd0 : src_q + 2'd1;
               state_q      <= S_IDLE;
`ifdef BUS_STATS_EN
               case (op_q)
                  OP_RD:   if (stat_read_miss  != 8'hFF) stat_read_miss  <= stat_read_miss  + 8'd1;
                  OP_WR:   if (stat_write_miss != 8'hFF) stat_write_miss <= stat_write_miss + 8'd1;
                  OP_INV:  if (stat_invalidate != 8'hFF) stat_invalidate <= stat_invalidate + 8'd1;
                  default: ;
               endcase
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign grant         = grant_q;
   assign snoop_valid   = snoop_valid_q;
   assign snoop_op      = snoop_op_q;
   assign snoop_address = snoop_addr_q;
   assign snoop_src     = snoop_src_q;
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// tb/tb_snoop_bus_controller.sv - self-checking bench for snoop_bus_controller
module tb_snoop_bus_controller;

   localparam int N  = 2;
   localparam int AW = 3;
   localparam int DW = 4;
   localparam int ML = 2;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic [N-1:0]      req_read_miss, req_write_miss, req_invalidate, req_wb_valid;
   logic [N*AW-1:0]   req_address, req_wb_address;
   logic [N*DW-1:0]   req_wb_data, snoop_data;
   logic [N-1:0]      snoop_hit_modified;
   logic [N-1:0]      grant, resp_valid;
   logic              snoop_valid, busy;
   logic [1:0]        snoop_op, snoop_src;
   logic [AW-1:0]     snoop_address;
   logic [DW-1:0]     resp_data;

   snoop_bus_controller #(.N_CPU(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)) dut (
      .clock              (clock),
      .reset_n            (reset_n),
      .req_read_miss      (req_read_miss),
      .req_write_miss     (req_write_miss),
      .req_invalidate     (req_invalidate),
      .req_address        (req_address),
      .req_wb_valid       (req_wb_valid),
      .req_wb_address     (req_wb_address),
      .req_wb_data        (req_wb_data),
      .grant              (grant),
      .snoop_valid        (snoop_valid),
      .snoop_op           (snoop_op),
      .snoop_address      (snoop_address),
      .snoop_src          (snoop_src),
      .snoop_hit_modified (snoop_hit_modified),
      .snoop_data         (snoop_data),
      .resp_valid         (resp_valid),
      .resp_data          (resp_data),
      .busy               (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int cpu; int rm; int wm; int inv; int addr;
      int wbv; int wba; int wbd; int hit; int hitd;
      int exp_op; int exp_data; int exp_lat;
   } vec_t;

   typedef struct { int cpu; int data; } resp_t;

   resp_t sbq[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Scoreboard: every response must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (resp_valid != '0) begin
         if (sbq.size() == 0) begin
            check("unexpected_resp", int'(resp_valid), 0);
         end else begin
            resp_t e;
            e = sbq.pop_front();
            check("resp_valid_vec", int'(resp_valid), 1 << e.cpu);
            check("resp_data", int'(resp_data), e.data);
         end
      end
   end

   task automatic clear_inputs();
      req_read_miss      = '0;
      req_write_miss     = '0;
      req_invalidate     = '0;
      req_address        = '0;
      req_wb_valid       = '0;
      req_wb_address     = '0;
      req_wb_data        = '0;
      snoop_hit_modified = '0;
      snoop_data         = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   // Entered just after a clock edge with the DUT idle; that cycle is cycle 0.
   task automatic run_txn(input vec_t v, input int idx);
      int snoop_cyc = -1;
      int resp_cyc  = -1;
      int hit_at    = -1;
      req_read_miss[v.cpu]                = (v.rm != 0);
      req_write_miss[v.cpu]               = (v.wm != 0);
      req_invalidate[v.cpu]               = (v.inv != 0);
      req_address[v.cpu*AW +: AW]         = AW'(v.addr);
      req_wb_valid[v.cpu]                 = (v.wbv != 0);
      req_wb_address[v.cpu*AW +: AW]      = AW'(v.wba);
      req_wb_data[v.cpu*DW +: DW]         = DW'(v.wbd);
      sbq.push_back('{v.cpu, v.exp_data});
      for (int n = 1; n <= 30 && resp_cyc < 0; n++) begin
         @(posedge clock);
         #1;
         if (n == hit_at) begin
            snoop_hit_modified = N'(v.hit);
            for (int c = 0; c < N; c++) snoop_data[c*DW +: DW] = DW'(v.hitd);
         end
         if (n == hit_at + 1) begin
            snoop_hit_modified = '0;
            snoop_data         = '0;
         end
         if (n == 1) begin
            check($sformatf("t%0d_grant", idx), int'(grant), 1 << v.cpu);
            check($sformatf("t%0d_busy", idx), int'(busy), 1);
         end
         if (snoop_valid) begin
            snoop_cyc = n;
            hit_at    = n + 1;
            check($sformatf("t%0d_snoop_op", idx), int'(snoop_op), v.exp_op);
            check($sformatf("t%0d_snoop_addr", idx), int'(snoop_address), v.addr);
            check($sformatf("t%0d_snoop_src", idx), int'(snoop_src), v.cpu);
         end
         if (resp_valid != '0) resp_cyc = n;
      end
      check($sformatf("t%0d_snoop_cycle", idx), snoop_cyc, 2);
      check($sformatf("t%0d_latency", idx), resp_cyc, v.exp_lat);
      @(posedge clock);
      #1;
      clear_inputs();
      check($sformatf("t%0d_idle_busy", idx), int'(busy), 0);
      check($sformatf("t%0d_idle_grant", idx), int'(grant), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   vec_t tbl[13];
   int   cnt0, cnt1;
   logic drop0, drop1;

   initial begin
      // cpu rm wm inv addr wbv wba wbd hit hitd | op data lat
      tbl[0]  = '{0, 1, 0, 0, 5, 0, 0, 0,  0, 0,  1, 0,  4+ML}; // cold read
      tbl[1]  = '{1, 1, 0, 0, 2, 0, 0, 0,  1, 10, 1, 10, 4};    // flush from CPU0
      tbl[2]  = '{0, 1, 0, 0, 2, 0, 0, 0,  0, 0,  1, 10, 4+ML}; // flushed data now in memory
      tbl[3]  = '{0, 0, 1, 0, 3, 1, 3, 7,  0, 0,  2, 7,  4+ML}; // victim at same address
      tbl[4]  = '{0, 1, 0, 0, 1, 1, 6, 3,  0, 0,  1, 0,  4+ML}; // victim elsewhere: mem[6]=3
      tbl[5]  = '{1, 0, 0, 1, 6, 0, 0, 0,  0, 0,  3, 0,  4};    // invalidate
      tbl[6]  = '{1, 1, 0, 0, 6, 0, 0, 0,  0, 0,  1, 3,  4+ML}; // invalidate left memory alone
      tbl[7]  = '{1, 1, 0, 0, 3, 0, 0, 0,  2, 5,  1, 7,  4+ML}; // own hit ignored
      tbl[8]  = '{0, 1, 1, 1, 1, 0, 0, 0,  0, 0,  2, 0,  4+ML}; // write miss wins priority
      tbl[9]  = '{1, 1, 0, 1, 4, 0, 0, 0,  1, 9,  3, 0,  4};    // invalidate beats read, flush to mem
      tbl[10] = '{0, 1, 0, 0, 4, 0, 0, 0,  0, 0,  1, 9,  4+ML}; // flush during invalidate stored
      tbl[11] = '{0, 1, 0, 0, 0, 1, 7, 14, 0, 0,  1, 0,  4+ML}; // victim to addr 7
      tbl[12] = '{1, 0, 1, 0, 7, 0, 0, 0,  0, 0,  2, 14, 4+ML}; // other CPU sees victim

      clear_inputs();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_grant", int'(grant), 0);
      check("rst_snoop_valid", int'(snoop_valid), 0);
      check("rst_snoop_op", int'(snoop_op), 0);
      check("rst_snoop_address", int'(snoop_address), 0);
      check("rst_snoop_src", int'(snoop_src), 0);
      check("rst_resp_valid", int'(resp_valid), 0);
      check("rst_resp_data", int'(resp_data), 0);
      check("rst_busy", int'(busy), 0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      for (int i = 0; i < 13; i++) run_txn(tbl[i], i);

      // Round robin from reset; CPU0 keeps requesting after its first service.
      do_reset();
      req_read_miss        = 2'b11;
      req_address[0 +: AW] = 3'd3;
      req_address[AW +: AW] = 3'd7;
      sbq.push_back('{0, 0});
      sbq.push_back('{1, 0});
      sbq.push_back('{0, 0});
      cnt0  = 0;
      cnt1  = 0;
      drop0 = 1'b0;
      drop1 = 1'b0;
      for (int n = 0; n < 80 && !(cnt0 == 2 && cnt1 == 1); n++) begin
         @(posedge clock);
         #1;
         if (drop0) begin req_read_miss[0] = 1'b0; drop0 = 1'b0; end
         if (drop1) begin req_read_miss[1] = 1'b0; drop1 = 1'b0; end
         if (resp_valid[0]) begin cnt0++; if (cnt0 == 2) drop0 = 1'b1; end
         if (resp_valid[1]) begin cnt1++; drop1 = 1'b1; end
      end
      @(posedge clock);
      #1;
      clear_inputs();
      check("rr_cpu0_served", cnt0, 2);
      check("rr_cpu1_served", cnt1, 1);
      check("rr_sb_drained", sbq.size(), 0);

      // Reset while waiting on memory: aborts silently.
      @(posedge clock);
      #1;
      req_read_miss[0]     = 1'b1;
      req_address[0 +: AW] = 3'd5;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clock);
         #1;
      end
      check("mid_busy_before_reset", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_grant", int'(grant), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_snoop_valid", int'(snoop_valid), 0);
      check("mid_rst_resp_valid", int'(resp_valid), 0);
      clear_inputs();
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      run_txn('{1, 1, 0, 0, 5, 0, 0, 0, 0, 0, 1, 0, 4+ML}, 99);

      check("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
